// File: rtl/dmem_arb_pkg.sv
// Shared types and default sizes for the data-memory port arbiter.
// Optional statistics counters are enabled with the DMEM_ARB_STATS_EN macro.
package dmem_arb_pkg;

   localparam int ADDR_W_DEF     = 15;
   localparam int DATA_W_DEF     = 32;
   localparam int RD_LAT_DEF     = 1;
   localparam int STARVE_LIM_DEF = 4;
   localparam int STAT_W         = 16;

   // Arbiter sequencing: free to issue, or waiting on the single outstanding read.
   typedef enum logic {
      IDLE    = 1'b0,
      WAIT_RD = 1'b1
   } arb_state_e;

   // Which requester owns the outstanding read.
   typedef enum logic {
      OWN_CPU  = 1'b0,
      OWN_HOST = 1'b1
   } owner_e;

   // Saturating increment used by the statistics counters.
   function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] value);
      return (value == {STAT_W{1'b1}}) ? value : value + 1'b1;
   endfunction

endpackage

// File: rtl/dmem_arb_starve_ctr.sv
// Host starvation counter: counts CPU grants taken while the host waits and
// raises force_host once the limit is reached so the host wins the next issue.
module dmem_arb_starve_ctr
   import dmem_arb_pkg::*;
#(
   parameter int STARVE_LIM = STARVE_LIM_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic host_req,
   input  logic cpu_gnt,
   input  logic host_gnt,
   output logic force_host
);

   localparam int CNT_W = (STARVE_LIM < 1) ? 1 : $clog2(STARVE_LIM + 1);

   logic [CNT_W-1:0] cnt_q;

   // Count CPU grants while the host is waiting; any host grant or host idle clears.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (host_gnt || !host_req) begin
         cnt_q <= '0;
      end else if (cpu_gnt && (cnt_q != CNT_W'(STARVE_LIM))) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign force_host = (cnt_q == CNT_W'(STARVE_LIM));

endmodule

// File: rtl/dmem_port_arbiter.sv
// Arbiter sharing the single-port data memory between the CPU load/store path
// and a host loader. One access per cycle, one outstanding read, CPU priority
// with host anti-starvation. Define DMEM_ARB_STATS_EN to add grant/stall counters.
module dmem_port_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int ADDR_W     = ADDR_W_DEF,
   parameter int DATA_W     = DATA_W_DEF,
   parameter int RD_LAT     = RD_LAT_DEF,
   parameter int STARVE_LIM = STARVE_LIM_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_gnt,
   output logic              cpu_rvalid,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_stall,
   input  logic              host_req,
   input  logic              host_we,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic [DATA_W-1:0] host_wdata,
   output logic              host_gnt,
   output logic              host_rvalid,
   output logic [DATA_W-1:0] host_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
`ifdef DMEM_ARB_STATS_EN
   ,
   output logic [STAT_W-1:0] cpu_grant_cnt,
   output logic [STAT_W-1:0] host_grant_cnt,
   output logic [STAT_W-1:0] stall_cycle_cnt
`endif
);

   localparam int LAT_W = $clog2(RD_LAT + 1);

   arb_state_e        state_q, state_d;
   owner_e            owner_q, owner_d;
   logic [LAT_W-1:0]  lat_q, lat_d;
   logic              force_host;
   logic              host_win;
   logic              cpu_win;
   logic              rd_done;
   logic [DATA_W-1:0] cpu_rdata_q;
   logic [DATA_W-1:0] host_rdata_q;

   dmem_arb_starve_ctr #(
      .STARVE_LIM (STARVE_LIM)
   ) u_starve_ctr (
      .clk        (clk),
      .rst        (rst),
      .host_req   (host_req),
      .cpu_gnt    (cpu_gnt),
      .host_gnt   (host_gnt),
      .force_host (force_host)
   );

   // CPU wins ties unless the host has waited through STARVE_LIM CPU grants.
   assign host_win = host_req & (~cpu_req | force_host);
   assign cpu_win  = cpu_req & ~host_win;

   // FSM state, read owner and read-latency counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         owner_q <= OWN_CPU;
         lat_q   <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         lat_q   <= lat_d;
      end
   end

   // Next state, issue muxing, grant/rvalid pulses and stall; all quiet during reset.
   // NOTE: every output of this block gets a default first so no latch can be inferred.
   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      lat_d       = lat_q;
      cpu_gnt     = 1'b0;
      host_gnt    = 1'b0;
      mem_en      = 1'b0;
      mem_we      = 1'b0;
      mem_addr    = '0;
      mem_wdata   = '0;
      rd_done     = 1'b0;
      cpu_rvalid  = 1'b0;
      host_rvalid = 1'b0;
      cpu_stall   = 1'b0;
      if (!rst) begin
         case (state_q)
            IDLE: begin
               if (host_win) begin
                  host_gnt  = 1'b1;
                  mem_en    = 1'b1;
                  mem_we    = host_we;
                  mem_addr  = host_addr;
                  mem_wdata = host_wdata;
                  if (!host_we) begin
                     state_d = WAIT_RD;
                     owner_d = OWN_HOST;
                     lat_d   = LAT_W'(1);
                  end
               end else if (cpu_win) begin
                  cpu_gnt   = 1'b1;
                  mem_en    = 1'b1;
                  mem_we    = cpu_we;
                  mem_addr  = cpu_addr;
                  mem_wdata = cpu_wdata;
                  if (!cpu_we) begin
                     state_d = WAIT_RD;
                     owner_d = OWN_CPU;
                     lat_d   = LAT_W'(1);
                  end
               end
            end
            WAIT_RD: begin
               // lat_q counts cycles since the grant; data arrives after RD_LAT of them.
               if (lat_q == LAT_W'(RD_LAT)) begin
                  rd_done = 1'b1;
                  state_d = IDLE;
                  lat_d   = '0;
               end else begin
                  lat_d = lat_q + 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
         cpu_rvalid  = rd_done & (owner_q == OWN_CPU);
         host_rvalid = rd_done & (owner_q == OWN_HOST);
         // A CPU read stalls from its grant cycle until (not including) its rvalid cycle.
         cpu_stall = (cpu_req & ~cpu_gnt)
                   | (cpu_gnt & ~cpu_we)
                   | ((state_q == WAIT_RD) & (owner_q == OWN_CPU) & ~cpu_rvalid);
      end
   end

   // Capture read data on each owner's rvalid and hold it until the next one.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cpu_rdata_q  <= '0;
         host_rdata_q <= '0;
      end else begin
         if (cpu_rvalid)  cpu_rdata_q  <= mem_rdata;
         if (host_rvalid) host_rdata_q <= mem_rdata;
      end
   end

   // Present memory data directly on the rvalid cycle, then the held copy.
   assign cpu_rdata  = cpu_rvalid  ? mem_rdata : cpu_rdata_q;
   assign host_rdata = host_rvalid ? mem_rdata : host_rdata_q;

`ifdef DMEM_ARB_STATS_EN
   // Saturating grant and stall statistics.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cpu_grant_cnt   <= '0;
         host_grant_cnt  <= '0;
         stall_cycle_cnt <= '0;
      end else begin
         if (cpu_gnt)   cpu_grant_cnt   <= sat_inc(cpu_grant_cnt);
         if (host_gnt)  host_grant_cnt  <= sat_inc(host_grant_cnt);
         if (cpu_stall) stall_cycle_cnt <= sat_inc(stall_cycle_cnt);
      end
   end
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: directed scenarios plus a
// randomized run against a cycle-level reference model of the arbitration rules.
module tb_dmem_port_arbiter;

   localparam int ADDR_W     = 15;
   localparam int DATA_W     = 32;
   localparam int RD_LAT     = 1;
   localparam int STARVE_LIM = 4;

   logic              clk;
   logic              rst;
   logic              cpu_req, cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic              cpu_gnt, cpu_rvalid, cpu_stall;
   logic [DATA_W-1:0] cpu_rdata;
   logic              host_req, host_we;
   logic [ADDR_W-1:0] host_addr;
   logic [DATA_W-1:0] host_wdata;
   logic              host_gnt, host_rvalid;
   logic [DATA_W-1:0] host_rdata;
   logic              mem_en, mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
`ifdef DMEM_ARB_STATS_EN
   logic [15:0]       cpu_grant_cnt, host_grant_cnt, stall_cycle_cnt;
`endif

   int n_cmp = 0;
   int n_err = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   dmem_port_arbiter #(
      .ADDR_W     (ADDR_W),
      .DATA_W     (DATA_W),
      .RD_LAT     (RD_LAT),
      .STARVE_LIM (STARVE_LIM)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .cpu_req     (cpu_req),
      .cpu_we      (cpu_we),
      .cpu_addr    (cpu_addr),
      .cpu_wdata   (cpu_wdata),
      .cpu_gnt     (cpu_gnt),
      .cpu_rvalid  (cpu_rvalid),
      .cpu_rdata   (cpu_rdata),
      .cpu_stall   (cpu_stall),
      .host_req    (host_req),
      .host_we     (host_we),
      .host_addr   (host_addr),
      .host_wdata  (host_wdata),
      .host_gnt    (host_gnt),
      .host_rvalid (host_rvalid),
      .host_rdata  (host_rdata),
      .mem_en      (mem_en),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata)
`ifdef DMEM_ARB_STATS_EN
      ,
      .cpu_grant_cnt   (cpu_grant_cnt),
      .host_grant_cnt  (host_grant_cnt),
      .stall_cycle_cnt (stall_cycle_cnt)
`endif
   );

   // Data memory model: synchronous write, read data RD_LAT cycles after the strobe.
   logic [DATA_W-1:0] mem     [0:(1<<ADDR_W)-1];
   logic [DATA_W-1:0] rd_pipe [0:RD_LAT-1];
   logic [DATA_W-1:0] ref_mem [0:(1<<ADDR_W)-1];

   always @(posedge clk) begin
      if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
      for (int i = RD_LAT - 1; i >= 1; i--) rd_pipe[i] <= rd_pipe[i-1];
      rd_pipe[0] <= (mem_en && !mem_we) ? mem[mem_addr] : 32'hBAD0_BAD0;
   end
   assign mem_rdata = rd_pipe[RD_LAT-1];

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_cpu(input logic req, input logic we, input logic [ADDR_W-1:0] a,
                            input logic [DATA_W-1:0] d);
      cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = d;
   endtask

   task automatic drive_host(input logic req, input logic we, input logic [ADDR_W-1:0] a,
                             input logic [DATA_W-1:0] d);
      host_req = req; host_we = we; host_addr = a; host_wdata = d;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive_cpu(1'b1, 1'b0, 15'h0001, 32'h0);
      drive_host(1'b1, 1'b0, 15'h0002, 32'h0);
      repeat (2) @(negedge clk);
      n_cmp++;
      if ({cpu_gnt, host_gnt, mem_en, mem_we, cpu_stall, cpu_rvalid, host_rvalid} !== 7'b0) begin
         n_err++;
         $display("FAIL reset_ctrl: got %b expected 0000000",
                  {cpu_gnt, host_gnt, mem_en, mem_we, cpu_stall, cpu_rvalid, host_rvalid});
      end
      n_cmp++;
      if (cpu_rdata !== 32'h0) begin
         n_err++; $display("FAIL reset_cpu_rdata: got %h expected 0", cpu_rdata);
      end
      n_cmp++;
      if (host_rdata !== 32'h0) begin
         n_err++; $display("FAIL reset_host_rdata: got %h expected 0", host_rdata);
      end
      next_cycle();
      rst = 1'b0;
      drive_cpu(1'b0, 1'b0, '0, '0);
      drive_host(1'b0, 1'b0, '0, '0);
      next_cycle();
   endtask

   task automatic test_cpu_write();
      drive_cpu(1'b1, 1'b1, 15'h0010, 32'hDEADBEEF);
      @(negedge clk);
      n_cmp++;
      if ({cpu_gnt, host_gnt, mem_en, mem_we, cpu_stall} !== 5'b10110) begin
         n_err++;
         $display("FAIL wr_ctrl: got %b expected 10110", {cpu_gnt, host_gnt, mem_en, mem_we, cpu_stall});
      end
      n_cmp++;
      if (mem_addr !== 15'h0010) begin
         n_err++; $display("FAIL wr_addr: got %h expected 0010", mem_addr);
      end
      n_cmp++;
      if (mem_wdata !== 32'hDEADBEEF) begin
         n_err++; $display("FAIL wr_data: got %h expected deadbeef", mem_wdata);
      end
      next_cycle();
      drive_cpu(1'b0, 1'b0, '0, '0);
      @(negedge clk);
      n_cmp++;
      if ({cpu_gnt, mem_en, cpu_stall} !== 3'b000) begin
         n_err++; $display("FAIL wr_after: got %b expected 000", {cpu_gnt, mem_en, cpu_stall});
      end
      next_cycle();
   endtask

   task automatic test_cpu_read();
      drive_cpu(1'b1, 1'b0, 15'h0010, 32'h0);
      @(negedge clk);
      n_cmp++;
      if ({cpu_gnt, mem_en, mem_we, cpu_stall, cpu_rvalid} !== 5'b11010) begin
         n_err++;
         $display("FAIL rd_issue: got %b expected 11010", {cpu_gnt, mem_en, mem_we, cpu_stall, cpu_rvalid});
      end
      next_cycle();
      drive_cpu(1'b0, 1'b0, '0, '0);
      @(negedge clk);
      n_cmp++;
      if ({cpu_gnt, cpu_stall, cpu_rvalid} !== 3'b001) begin
         n_err++; $display("FAIL rd_valid: got %b expected 001", {cpu_gnt, cpu_stall, cpu_rvalid});
      end
      n_cmp++;
      if (cpu_rdata !== 32'hDEADBEEF) begin
         n_err++; $display("FAIL rd_data: got %h expected deadbeef", cpu_rdata);
      end
      next_cycle();
      @(negedge clk);
      n_cmp++;
      if ({cpu_rvalid, cpu_rdata} !== {1'b0, 32'hDEADBEEF}) begin
         n_err++; $display("FAIL rd_hold: got %b/%h expected 0/deadbeef", cpu_rvalid, cpu_rdata);
      end
      next_cycle();
   endtask

   task automatic test_starvation();
      drive_cpu(1'b1, 1'b1, 15'h0030, 32'h0000_00C0);
      drive_host(1'b1, 1'b1, 15'h0020, 32'h0000_1234);
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         n_cmp++;
         if ({cpu_gnt, host_gnt} !== ((i % 5 == 4) ? 2'b01 : 2'b10)) begin
            n_err++;
            $display("FAIL starve_cycle%0d: got cpu/host %b expected %b", i, {cpu_gnt, host_gnt},
                     (i % 5 == 4) ? 2'b01 : 2'b10);
         end
         next_cycle();
      end
      drive_cpu(1'b0, 1'b0, '0, '0);
      drive_host(1'b0, 1'b0, '0, '0);
      next_cycle();
   endtask

   task automatic test_host_read_blocks_cpu();
      drive_host(1'b1, 1'b0, 15'h0010, 32'h0);
      @(negedge clk);
      n_cmp++;
      if ({host_gnt, mem_en, mem_we, cpu_stall} !== 4'b1100) begin
         n_err++; $display("FAIL hrd_issue: got %b expected 1100", {host_gnt, mem_en, mem_we, cpu_stall});
      end
      next_cycle();
      drive_host(1'b0, 1'b0, '0, '0);
      drive_cpu(1'b1, 1'b1, 15'h0040, 32'h5555_5555);
      @(negedge clk);
      n_cmp++;
      if ({host_rvalid, cpu_gnt, mem_en, cpu_stall} !== 4'b1001) begin
         n_err++;
         $display("FAIL hrd_block: got %b expected 1001", {host_rvalid, cpu_gnt, mem_en, cpu_stall});
      end
      n_cmp++;
      if (host_rdata !== 32'hDEADBEEF) begin
         n_err++; $display("FAIL hrd_data: got %h expected deadbeef", host_rdata);
      end
      next_cycle();
      @(negedge clk);
      n_cmp++;
      if ({cpu_gnt, cpu_stall, mem_addr} !== {2'b10, 15'h0040}) begin
         n_err++; $display("FAIL hrd_cpu_after: got %b/%h expected 10/0040", {cpu_gnt, cpu_stall}, mem_addr);
      end
      next_cycle();
      drive_cpu(1'b0, 1'b0, '0, '0);
      next_cycle();
   endtask

   task automatic test_reset_mid_read();
      drive_cpu(1'b1, 1'b0, 15'h0010, 32'h0);
      @(negedge clk);
      n_cmp++;
      if (cpu_gnt !== 1'b1) begin
         n_err++; $display("FAIL rmr_gnt: got %b expected 1", cpu_gnt);
      end
      next_cycle();
      rst = 1'b1;
      drive_cpu(1'b0, 1'b0, '0, '0);
      #1;
      n_cmp++;
      if ({cpu_rvalid, cpu_stall, mem_en, cpu_rdata} !== {3'b000, 32'h0}) begin
         n_err++;
         $display("FAIL rmr_async: got %b/%h expected 000/0", {cpu_rvalid, cpu_stall, mem_en}, cpu_rdata);
      end
      next_cycle();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_cmp++;
         if ({cpu_rvalid, cpu_rdata} !== {1'b0, 32'h0}) begin
            n_err++; $display("FAIL rmr_after%0d: got %b/%h expected 0/0", i, cpu_rvalid, cpu_rdata);
         end
         next_cycle();
      end
   endtask

   // Randomized traffic against a cycle-level model of the arbitration rules.
   task automatic test_random();
      int                rd_left   = 0;    // cycles until the outstanding read returns
      bit                rd_is_cpu = 1'b0;
      logic [DATA_W-1:0] rd_exp    = '0;
      int                starve    = 0;
      logic [DATA_W-1:0] exp_cpu_rd  = '0;
      logic [DATA_W-1:0] exp_host_rd = '0;
      bit                prev_cg = 1'b0, prev_hg = 1'b0;
      bit                e_cg, e_hg, e_cv, e_hv, e_en, e_we, e_st;
      logic [ADDR_W-1:0] e_addr;
      logic [DATA_W-1:0] e_wd;
      logic [6:0]        obs, expv;

      for (int a = 0; a < 16; a++) begin
         logic [DATA_W-1:0] v;
         v = $urandom;
         mem[15'h0100 + a]     = v;
         ref_mem[15'h0100 + a] = v;
      end

      for (int cyc = 0; cyc < 3000; cyc++) begin
         if (!cpu_req || prev_cg) begin
            if ($urandom_range(99) < 60)
               drive_cpu(1'b1, 1'($urandom_range(1)), 15'h0100 + 15'($urandom_range(15)), $urandom);
            else
               drive_cpu(1'b0, 1'b0, '0, '0);
         end else if ($urandom_range(99) < 5) begin
            drive_cpu(1'b0, 1'b0, '0, '0);
         end
         if (!host_req || prev_hg) begin
            if ($urandom_range(99) < 50)
               drive_host(1'b1, 1'($urandom_range(1)), 15'h0100 + 15'($urandom_range(15)), $urandom);
            else
               drive_host(1'b0, 1'b0, '0, '0);
         end else if ($urandom_range(99) < 5) begin
            drive_host(1'b0, 1'b0, '0, '0);
         end

         @(negedge clk);
         e_cg = 0; e_hg = 0; e_en = 0; e_we = 0; e_addr = '0; e_wd = '0;
         e_cv = (rd_left == 1) && rd_is_cpu;
         e_hv = (rd_left == 1) && !rd_is_cpu;
         if (rd_left == 0) begin
            if (host_req && (!cpu_req || starve == STARVE_LIM)) begin
               e_hg = 1; e_en = 1; e_we = host_we; e_addr = host_addr; e_wd = host_wdata;
            end else if (cpu_req) begin
               e_cg = 1; e_en = 1; e_we = cpu_we; e_addr = cpu_addr; e_wd = cpu_wdata;
            end
         end
         e_st = (cpu_req && !e_cg) || (e_cg && !cpu_we) || (rd_left > 1 && rd_is_cpu);
         if (e_cv) exp_cpu_rd  = rd_exp;
         if (e_hv) exp_host_rd = rd_exp;

         obs  = {cpu_gnt, host_gnt, cpu_rvalid, host_rvalid, cpu_stall, mem_en, mem_we};
         expv = {e_cg, e_hg, e_cv, e_hv, e_st, e_en, e_we};
         n_cmp++;
         if (obs !== expv) begin
            n_err++;
            $display("FAIL rnd_ctrl cyc%0d: got gnt/gnt/rv/rv/stall/en/we %b expected %b", cyc, obs, expv);
         end
         if (e_en) begin
            n_cmp++;
            if (mem_addr !== e_addr || (e_we && mem_wdata !== e_wd)) begin
               n_err++;
               $display("FAIL rnd_mem cyc%0d: got %h/%h expected %h/%h", cyc, mem_addr, mem_wdata, e_addr, e_wd);
            end
         end
         n_cmp++;
         if (cpu_rdata !== exp_cpu_rd || host_rdata !== exp_host_rd) begin
            n_err++;
            $display("FAIL rnd_rdata cyc%0d: got %h/%h expected %h/%h", cyc, cpu_rdata, host_rdata,
                     exp_cpu_rd, exp_host_rd);
         end

         if (rd_left > 0) rd_left--;
         if (e_en) begin
            if (e_we) ref_mem[e_addr] = e_wd;
            else begin
               rd_left   = RD_LAT;
               rd_is_cpu = e_cg;
               rd_exp    = ref_mem[e_addr];
            end
         end
         if (e_hg || !host_req) starve = 0;
         else if (e_cg) starve++;
         prev_cg = e_cg;
         prev_hg = e_hg;
         next_cycle();
      end
      drive_cpu(1'b0, 1'b0, '0, '0);
      drive_host(1'b0, 1'b0, '0, '0);
      repeat (RD_LAT + 2) next_cycle();
   endtask

`ifdef DMEM_ARB_STATS_EN
   task automatic test_stats_saturate();
      rst = 1'b1;
      next_cycle();
      rst = 1'b0;
      drive_cpu(1'b1, 1'b1, 15'h0050, 32'h0000_0001);
      repeat (10) next_cycle();
      n_cmp++;
      if (cpu_grant_cnt !== 16'd10) begin
         n_err++; $display("FAIL stats_cpu10: got %0d expected 10", cpu_grant_cnt);
      end
      repeat (69990) next_cycle();
      n_cmp++;
      if (cpu_grant_cnt !== 16'hFFFF) begin
         n_err++; $display("FAIL stats_cpu_sat: got %h expected ffff", cpu_grant_cnt);
      end
      n_cmp++;
      if ({host_grant_cnt, stall_cycle_cnt} !== 32'h0) begin
         n_err++; $display("FAIL stats_other: got %h/%h expected 0/0", host_grant_cnt, stall_cycle_cnt);
      end
      drive_cpu(1'b0, 1'b0, '0, '0);
      next_cycle();
   endtask
`endif

   initial begin
      for (int a = 0; a < (1 << ADDR_W); a++) begin
         mem[a]     = '0;
         ref_mem[a] = '0;
      end
      for (int i = 0; i < RD_LAT; i++) rd_pipe[i] = '0;
      test_reset();
      test_cpu_write();
      test_cpu_read();
      test_starvation();
      test_host_read_blocks_cpu();
      test_reset_mid_read();
      test_random();
`ifdef DMEM_ARB_STATS_EN
      test_stats_saturate();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
